bypass_mc: RTL

Multi-channel execute-stage bypass unit. It accepts instruction tags from NCH independent dispatch channels that need no functional-unit work, and buffers each channel in its own DEPTH-entry FIFO. A round-robin arbiter forwards one tag per cycle to a single registered write-back port with valid/ready handshake. It sits between dispatch and the write-back arbiter and generalises the single-channel bypass unit in tag width, buffer depth and channel count.

---
 rtl/bypass_mc.sv | 114 +++++++++++
 1 files changed

// File: rtl/bypass_mc.sv
// Multi-channel bypass unit: per-channel tag FIFOs feeding one registered
// write-back port through a round-robin arbiter.
module bypass_mc #(
  parameter int NCH   = 2,
  parameter int TAGW  = 8,
  parameter int DEPTH = 2,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                flush_i,
  input  logic [NCH-1:0]      in_valid_i,
  input  logic [NCH*TAGW-1:0] in_itag_i,
  output logic [NCH-1:0]      in_full_o,
  output logic                wb_valid_o,
  output logic [TAGW-1:0]     wb_itag_o,
  output logic [CHW-1:0]      wb_ch_o,
  input  logic                wb_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TAGW-1:0] head [NCH];
  logic [NCH-1:0]  nonempty;
  logic [NCH-1:0]  pop;
  logic [CHW-1:0]  rr_reg;
  logic [CHW-1:0]  grant;
  logic            any_ready;
  logic            load;
  logic            do_pop;
  int              best_off;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [TAGW-1:0] mem [DEPTH];
      logic [PW-1:0]   wr_ptr_reg;
      logic [PW-1:0]   rd_ptr_reg;
      logic [CW-1:0]   cnt_reg;
      logic            wr;
      logic            rd;

      // A write while full is dropped even if the head pops this cycle.
      assign wr            = in_valid_i[gi] && !in_full_o[gi] && !flush_i;
      assign rd            = pop[gi];
      assign in_full_o[gi] = (cnt_reg == CW'(DEPTH));
      assign nonempty[gi]  = (cnt_reg != '0);
      assign head[gi]      = mem[rd_ptr_reg];

      always_ff @(posedge clk_i) begin
        if (wr) begin
          mem[wr_ptr_reg] <= in_itag_i[gi*TAGW +: TAGW];
        end
      end

      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else if (flush_i) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (wr) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (rd) rd_ptr_reg <= rd_ptr_reg + PW'(1);
          cnt_reg <= cnt_reg + CW'(wr) - CW'(rd);
        end
      end
    end
  endgenerate

  // Grant the non-empty channel at the smallest distance from rr.
  always_comb begin
    grant     = '0;
    any_ready = 1'b0;
    best_off  = NCH;
    for (int k = 0; k < NCH; k++) begin
      if (nonempty[k] && (((k - int'(rr_reg) + NCH) % NCH) < best_off)) begin
        best_off  = (k - int'(rr_reg) + NCH) % NCH;
        grant     = CHW'(k);
        any_ready = 1'b1;
      end
    end
  end

  assign load   = !wb_valid_o || wb_ready_i;
  assign do_pop = load && any_ready && !flush_i;
  assign pop    = do_pop ? (NCH'(1) << grant) : '0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wb_valid_o <= 1'b0;
      wb_itag_o  <= '0;
      wb_ch_o    <= '0;
      rr_reg     <= '0;
    end else if (flush_i) begin
      wb_valid_o <= 1'b0;
      rr_reg     <= '0;
    end else if (load) begin
      if (any_ready) begin
        wb_valid_o <= 1'b1;
        wb_itag_o  <= head[grant];
        wb_ch_o    <= grant;
        rr_reg     <= (grant == CHW'(NCH - 1)) ? '0 : grant + CHW'(1);
      end else begin
        wb_valid_o <= 1'b0;
      end
    end
  end

endmodule
